// File: rtl/mmio_bus_decoder_pkg.sv
// Shared definitions for the MMIO bus decoder: FSM encoding, default
// region map and error-counter sizing.
package mmio_bus_decoder_pkg;

  // Transaction FSM encoding.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_t;

  // Default four-slave map, slave 0 in the least significant word:
  //   slave 0:   0 ..  127
  //   slave 1: 128 ..  130
  //   slave 2: 256 ..  259
  //   slave 3: 512 .. 1023
  localparam logic [127:0] DEF_REGION_BASE  = {32'd512,  32'd256, 32'd128, 32'd0};
  localparam logic [127:0] DEF_REGION_LIMIT = {32'd1023, 32'd259, 32'd130, 32'd127};

  localparam int ERR_CNT_W = 8;

  // Saturating increment for the error counter.
  function automatic logic [ERR_CNT_W-1:0] err_cnt_inc(input logic [ERR_CNT_W-1:0] v);
    return (v == {ERR_CNT_W{1'b1}}) ? v : v + ERR_CNT_W'(1);
  endfunction

endpackage

// File: rtl/mmio_bus_decoder_addr_match.sv
// Combinational region lookup: reports whether an address falls in any
// slave window, which slave owns it (lowest index wins on overlap) and
// that slave's base address.
module addr_match
  import mmio_bus_decoder_pkg::*;
#(
  parameter int NUM_SLAVES = 4,
  parameter int ADDR_WIDTH = 32,
  parameter logic [NUM_SLAVES*ADDR_WIDTH-1:0] REGION_BASE  = DEF_REGION_BASE,
  parameter logic [NUM_SLAVES*ADDR_WIDTH-1:0] REGION_LIMIT = DEF_REGION_LIMIT,
  localparam int IDX_W = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1
) (
  input  logic [ADDR_WIDTH-1:0] addr,
  output logic                  hit,
  output logic [IDX_W-1:0]      idx,
  output logic [ADDR_WIDTH-1:0] base
);

  // Scan from the highest slave down so the lowest matching index is the
  // last assignment and therefore wins.
  always_comb begin
    hit  = 1'b0;
    idx  = '0;
    base = '0;
    for (int k = NUM_SLAVES - 1; k >= 0; k--) begin
      if ((addr >= REGION_BASE[k*ADDR_WIDTH +: ADDR_WIDTH]) &&
          (addr <= REGION_LIMIT[k*ADDR_WIDTH +: ADDR_WIDTH])) begin
        hit  = 1'b1;
        idx  = IDX_W'(k);
        base = REGION_BASE[k*ADDR_WIDTH +: ADDR_WIDTH];
      end
    end
  end

endmodule

// File: rtl/mmio_bus_decoder.sv
// MMIO bus decoder: routes one master request at a time to the owning
// slave region, waits for that slave's acknowledge (bounded by TIMEOUT)
// and returns a single-cycle response.
//
// Handshake: the master raises i_req with address/data stable; it is only
// sampled in IDLE. The response is the one-cycle o_ready strobe, with
// o_rdata/o_err valid only while o_ready=1. Toward the slaves, o_sel[k]
// stays high for the whole access and only i_sack[k] of the selected slave
// completes it; i_sdata slice k is sampled in the same cycle as i_sack[k].
module mmio_bus_decoder
  import mmio_bus_decoder_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_SLAVES = 4,
  parameter logic [NUM_SLAVES*ADDR_WIDTH-1:0] REGION_BASE  = DEF_REGION_BASE,
  parameter logic [NUM_SLAVES*ADDR_WIDTH-1:0] REGION_LIMIT = DEF_REGION_LIMIT,
  parameter int TIMEOUT = 15
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             i_req,
  input  logic                             i_we,
  input  logic [ADDR_WIDTH-1:0]            i_addr,
  input  logic [DATA_WIDTH-1:0]            i_wdata,
  output logic                             o_ready,
  output logic [DATA_WIDTH-1:0]            o_rdata,
  output logic                             o_err,
  output logic [NUM_SLAVES-1:0]            o_sel,
  output logic [NUM_SLAVES-1:0]            o_we,
  output logic [ADDR_WIDTH-1:0]            o_addr,
  output logic [DATA_WIDTH-1:0]            o_wdata,
  input  logic [NUM_SLAVES*DATA_WIDTH-1:0] i_sdata,
  input  logic [NUM_SLAVES-1:0]            i_sack,
  output logic [ADDR_WIDTH-1:0]            o_err_addr,
  output logic [ERR_CNT_W-1:0]             o_err_cnt
);

  localparam int IDX_W = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
  localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  state_t                  state_q;
  logic [IDX_W-1:0]        sel_idx_q;
  logic                    we_q;
  logic [ADDR_WIDTH-1:0]   abs_addr_q;
  logic [CNT_W-1:0]        wait_cnt;

  logic                    m_hit;
  logic [IDX_W-1:0]        m_idx;
  logic [ADDR_WIDTH-1:0]   m_base;
  logic [NUM_SLAVES-1:0]   hit_onehot;
  logic                    sel_ack;
  logic [DATA_WIDTH-1:0]   sel_sdata;

  addr_match #(
    .NUM_SLAVES  (NUM_SLAVES),
    .ADDR_WIDTH  (ADDR_WIDTH),
    .REGION_BASE (REGION_BASE),
    .REGION_LIMIT(REGION_LIMIT)
  ) u_addr_match (
    .addr(i_addr),
    .hit (m_hit),
    .idx (m_idx),
    .base(m_base)
  );

  // Only the selected slave's acknowledge and data lane matter.
  assign hit_onehot = NUM_SLAVES'(1) << m_idx;
  assign sel_ack    = i_sack[sel_idx_q];
  assign sel_sdata  = i_sdata[sel_idx_q*DATA_WIDTH +: DATA_WIDTH];

  // Transaction FSM with all outputs registered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      sel_idx_q  <= '0;
      we_q       <= 1'b0;
      abs_addr_q <= '0;
      wait_cnt   <= '0;
      o_ready    <= 1'b0;
      o_rdata    <= '0;
      o_err      <= 1'b0;
      o_sel      <= '0;
      o_we       <= '0;
      o_addr     <= '0;
      o_wdata    <= '0;
      o_err_addr <= '0;
      o_err_cnt  <= '0;
    end else begin
      o_ready <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          o_rdata <= '0;
          o_err   <= 1'b0;
          if (i_req) begin
            abs_addr_q <= i_addr;
            if (m_hit) begin
              sel_idx_q <= m_idx;
              we_q      <= i_we;
              o_addr    <= i_addr - m_base;
              o_wdata   <= i_wdata;
              o_sel     <= hit_onehot;
              o_we      <= i_we ? hit_onehot : '0;
              wait_cnt  <= '0;
              state_q   <= ST_ACCESS;
            end else begin
              // Unmapped: answer immediately with an error.
              o_ready    <= 1'b1;
              o_err      <= 1'b1;
              o_err_addr <= i_addr;
              o_err_cnt  <= err_cnt_inc(o_err_cnt);
              state_q    <= ST_RESP;
            end
          end
        end

        ST_ACCESS: begin
          if (sel_ack) begin
            // Ack beats timeout when both land in the same cycle.
            o_ready <= 1'b1;
            o_err   <= 1'b0;
            o_rdata <= we_q ? '0 : sel_sdata;
            o_sel   <= '0;
            o_we    <= '0;
            state_q <= ST_RESP;
          end else if (wait_cnt == CNT_W'(TIMEOUT)) begin
            o_ready    <= 1'b1;
            o_err      <= 1'b1;
            o_rdata    <= '0;
            o_err_addr <= abs_addr_q;
            o_err_cnt  <= err_cnt_inc(o_err_cnt);
            o_sel      <= '0;
            o_we       <= '0;
            state_q    <= ST_RESP;
          end else begin
            wait_cnt <= wait_cnt + CNT_W'(1);
          end
        end

        ST_RESP: begin
          o_rdata <= '0;
          o_err   <= 1'b0;
          state_q <= ST_IDLE;
        end

        default: begin
          o_sel   <= '0;
          o_we    <= '0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mmio_bus_decoder.sv
// Bench for mmio_bus_decoder: directed transactions, a transaction-level
// expectation model checked every cycle, and literal spot checks.
module tb_mmio_bus_decoder;

  localparam int TMO = 15;

  // ---------------- clock / reset / DUT ----------------
  logic          clk = 1'b0;
  logic          rst;
  logic          i_req;
  logic          i_we;
  logic [31:0]   i_addr;
  logic [31:0]   i_wdata;
  logic          o_ready;
  logic [31:0]   o_rdata;
  logic          o_err;
  logic [3:0]    o_sel;
  logic [3:0]    o_we;
  logic [31:0]   o_addr;
  logic [31:0]   o_wdata;
  logic [127:0]  i_sdata;
  logic [3:0]    i_sack;
  logic [31:0]   o_err_addr;
  logic [7:0]    o_err_cnt;

  always #5 clk = ~clk;

  mmio_bus_decoder dut (
    .clk       (clk),
    .rst       (rst),
    .i_req     (i_req),
    .i_we      (i_we),
    .i_addr    (i_addr),
    .i_wdata   (i_wdata),
    .o_ready   (o_ready),
    .o_rdata   (o_rdata),
    .o_err     (o_err),
    .o_sel     (o_sel),
    .o_we      (o_we),
    .o_addr    (o_addr),
    .o_wdata   (o_wdata),
    .i_sdata   (i_sdata),
    .i_sack    (i_sack),
    .o_err_addr(o_err_addr),
    .o_err_cnt (o_err_cnt)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [31:0] base_tab [4] = '{32'd0, 32'd128, 32'd256, 32'd512};
  logic [31:0] lim_tab  [4] = '{32'd127, 32'd130, 32'd259, 32'd1023};

  function automatic void model_decode(input logic [31:0] a, output logic hit,
                                       output int k, output logic [31:0] b);
    hit = 1'b0; k = 0; b = '0;
    for (int j = 0; j < 4; j++)
      if (!hit && a >= base_tab[j] && a <= lim_tab[j]) begin
        hit = 1'b1; k = j; b = base_tab[j];
      end
  endfunction

  // Expected outputs for the current cycle.
  logic        exp_ready, exp_err;
  logic [31:0] exp_rdata, exp_addr, exp_wdata, exp_err_addr;
  logic [3:0]  exp_sel, exp_we;
  int          exp_err_cnt;
  logic        check_en = 1'b0;

  task automatic set_idle();
    exp_ready = 1'b0; exp_err = 1'b0; exp_rdata = '0; exp_sel = '0; exp_we = '0;
  endtask

  task automatic bump_err(input logic [31:0] a);
    exp_err_addr = a;
    exp_err_cnt  = (exp_err_cnt >= 255) ? 255 : exp_err_cnt + 1;
  endtask

  // Observed values captured from the DUT for literal spot checks.
  int          req_t0, last_lat;
  logic [31:0] got_rdata, got_oaddr, got_owdata;
  logic        got_err;
  logic [3:0]  got_osel, got_owe;

  // Per-cycle compare against the model, sampled mid-cycle.
  always @(negedge clk) begin
    if (check_en) begin
      if (o_ready) begin
        last_lat  = cyc - req_t0 + 1;
        got_rdata = o_rdata;
        got_err   = o_err;
      end
      if (o_sel != 4'b0) begin
        got_osel = o_sel; got_owe = o_we; got_oaddr = o_addr; got_owdata = o_wdata;
      end
      chk("ready",    64'(o_ready),    64'(exp_ready));
      chk("err",      64'(o_err),      64'(exp_err));
      chk("rdata",    64'(o_rdata),    64'(exp_rdata));
      chk("sel",      64'(o_sel),      64'(exp_sel));
      chk("we",       64'(o_we),       64'(exp_we));
      chk("err_addr", 64'(o_err_addr), 64'(exp_err_addr));
      chk("err_cnt",  64'(o_err_cnt),  64'(exp_err_cnt));
      if (exp_sel != 4'b0) begin
        chk("addr",  64'(o_addr),  64'(exp_addr));
        chk("wdata", 64'(o_wdata), 64'(exp_wdata));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One transaction starting in an IDLE cycle. ack_at is the ACCESS cycle
  // (1-based) in which the owning slave acks (0 = never); stray raises other
  // slaves' acks during ACCESS; rst_at pulses reset in that ACCESS cycle.
  task automatic do_txn(input logic [31:0] addr, input logic we, input logic [31:0] wdata,
                        input int ack_at, input logic [3:0] stray, input logic [31:0] sdata,
                        input int rst_at, input logic hold);
    logic        hit;
    int          k;
    logic [31:0] b;
    logic        done;
    model_decode(addr, hit, k, b);
    last_lat = -1; got_osel = '0; got_owe = '0; got_rdata = 'x; got_err = 1'bx;
    for (int j = 0; j < 4; j++) i_sdata[j*32 +: 32] = (j == k) ? sdata : (32'hBAD0_0000 + 32'(j));
    i_req = 1'b1; i_addr = addr; i_we = we; i_wdata = wdata; req_t0 = cyc;
    step();
    if (!hold) i_req = 1'b0;
    if (!hit) begin
      exp_ready = 1'b1; exp_err = 1'b1; exp_rdata = '0;
      bump_err(addr);
      step();
      set_idle();
      return;
    end
    exp_sel = 4'b1 << k; exp_we = we ? (4'b1 << k) : 4'b0;
    exp_addr = addr - b; exp_wdata = wdata;
    done = 1'b0;
    for (int n = 1; n <= TMO + 1 && !done; n++) begin
      i_sack = stray & ~(4'b1 << k);
      if (n == rst_at) begin
        rst = 1'b1;
        step();
        rst = 1'b0; i_sack = '0;
        set_idle(); exp_err_cnt = 0; exp_err_addr = '0;
        return;
      end
      if (n == ack_at) i_sack[k] = 1'b1;
      step();
      i_sack = '0;
      if (n == ack_at) begin
        exp_ready = 1'b1; exp_err = 1'b0; exp_rdata = we ? 32'h0 : sdata;
        exp_sel = '0; exp_we = '0; done = 1'b1;
      end else if (n == TMO + 1) begin
        // TIMEOUT waits have elapsed without an ack.
        exp_ready = 1'b1; exp_err = 1'b1; exp_rdata = '0;
        exp_sel = '0; exp_we = '0; bump_err(addr); done = 1'b1;
      end
    end
    step();
    set_idle();
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    rst = 1'b1; i_req = 1'b0; i_we = 1'b0; i_addr = '0; i_wdata = '0;
    i_sdata = '0; i_sack = '0;
    set_idle(); exp_addr = '0; exp_wdata = '0; exp_err_addr = '0; exp_err_cnt = 0;
    req_t0 = 0; last_lat = -1;
    step();
    check_en = 1'b1;
    step();
    chk("reset_ready", 64'(o_ready), 64'd0);
    chk("reset_cnt",   64'(o_err_cnt), 64'd0);
    rst = 1'b0;
    step();

    // Read at 0x05, immediate ack.
    do_txn(32'h5, 1'b0, 32'h0, 1, 4'b0, 32'hDEADBEEF, 0, 1'b0);
    chk("r5_lat",   64'(last_lat),  64'd3);
    chk("r5_rdata", 64'(got_rdata), 64'hDEADBEEF);
    chk("r5_err",   64'(got_err),   64'd0);
    chk("r5_sel",   64'(got_osel),  64'b0001);
    chk("r5_addr",  64'(got_oaddr), 64'd5);

    // Write at 129, ack after two waits.
    do_txn(32'd129, 1'b1, 32'h0F, 3, 4'b0, 32'h1234_5678, 0, 1'b0);
    chk("w129_lat",   64'(last_lat),   64'd5);
    chk("w129_we",    64'(got_owe),    64'b0010);
    chk("w129_addr",  64'(got_oaddr),  64'd1);
    chk("w129_wdata", 64'(got_owdata), 64'h0F);
    chk("w129_rdata", 64'(got_rdata),  64'd0);
    chk("w129_err",   64'(got_err),    64'd0);

    // Read at 0x200, no ack: timeout.
    do_txn(32'h200, 1'b0, 32'h0, 0, 4'b0, 32'hCAFE_F00D, 0, 1'b0);
    chk("to_lat",     64'(last_lat),   64'd18);
    chk("to_err",     64'(got_err),    64'd1);
    chk("to_erraddr", 64'(o_err_addr), 64'h200);
    chk("to_cnt",     64'(o_err_cnt),  64'd1);

    // Unmapped access at 200.
    do_txn(32'd200, 1'b0, 32'h0, 0, 4'b0, 32'h0, 0, 1'b0);
    chk("um_lat",     64'(last_lat),   64'd2);
    chk("um_err",     64'(got_err),    64'd1);
    chk("um_sel",     64'(got_osel),   64'd0);
    chk("um_erraddr", 64'(o_err_addr), 64'd200);
    chk("um_cnt",     64'(o_err_cnt),  64'd2);

    // Reset pulsed in the second ACCESS cycle of a slave-0 read.
    do_txn(32'h10, 1'b0, 32'h0, 0, 4'b0, 32'h1111_1111, 2, 1'b0);
    chk("rst_lat", 64'(last_lat),  64'hFFFF_FFFF_FFFF_FFFF);
    chk("rst_cnt", 64'(o_err_cnt), 64'd0);

    // Wrong-slave ack on slave 2 during a slave-0 read is ignored.
    do_txn(32'h7F, 1'b0, 32'h0, 3, 4'b0100, 32'h0A0B_0C0D, 0, 1'b0);
    chk("stray_lat",   64'(last_lat),  64'd5);
    chk("stray_rdata", 64'(got_rdata), 64'h0A0B_0C0D);

    // Ack on the very cycle the wait count reaches TIMEOUT still succeeds.
    do_txn(32'd258, 1'b0, 32'h0, TMO + 1, 4'b0, 32'h5555_AAAA, 0, 1'b0);
    chk("edge_lat",   64'(last_lat),  64'd18);
    chk("edge_err",   64'(got_err),   64'd0);
    chk("edge_rdata", 64'(got_rdata), 64'h5555_AAAA);
    chk("edge_addr",  64'(got_oaddr), 64'd2);

    // Held request: ignored during ACCESS/RESP, restarts right after RESP.
    do_txn(32'd130, 1'b0, 32'h0, 1, 4'b0, 32'h7777_0001, 0, 1'b1);
    do_txn(32'd1023, 1'b1, 32'hA5, 2, 4'b0, 32'h0, 0, 1'b1);
    chk("hold_lat",  64'(last_lat),  64'd4);
    chk("hold_addr", 64'(got_oaddr), 64'd511);
    i_req = 1'b0;
    step();

    // 300 unmapped accesses saturate the error counter.
    for (int i = 0; i < 300; i++)
      do_txn(32'd300 + 32'(i % 2), 1'b0, 32'h0, 0, 4'b0, 32'h0, 0, 1'b0);
    chk("sat_cnt",     64'(o_err_cnt),  64'd255);
    chk("sat_erraddr", 64'(o_err_addr), 64'd301);

    step();
    check_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
